avmm_wr_ack_burst_to_word_mc: RTL and testbench

AVMM_WR_ACK_BURST_TO_WORD_MC -- requirements
Module: avmm_wr_ack_burst_to_word_mc

---
 rtl/local_mem_cfg_pkg.sv | 8 +
 rtl/ofs_asp_pkg.sv | 21 ++
 rtl/wr_ack_word_cnt_ch.sv | 120 ++++++++++++
 rtl/avmm_wr_ack_burst_to_word_mc.sv | 54 +++++
 tb/tb_avmm_wr_ack_burst_to_word_mc.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/local_mem_cfg_pkg.sv
// Local-memory interface configuration shared by the write-ack converters.
// Supplies the default Avalon-MM burst count width.
package local_mem_cfg_pkg;

   // Avalon-MM burstcount width of the local memory ports.
   localparam int LOCAL_MEM_BURST_CNT_WIDTH = 7;

endpackage : local_mem_cfg_pkg

// File: rtl/ofs_asp_pkg.sv
// ASP-level shared types: per-channel pending-word counter and error status.
package ofs_asp_pkg;

   // Default width of a per-channel pending word-ack counter.
   localparam int WR_ACK_CNT_WIDTH = 10;

   typedef logic [WR_ACK_CNT_WIDTH-1:0] wr_ack_cnt_t;

   // Sticky error status of one write-ack channel.
   typedef struct packed {
      logic overflow;
      logic zero_burst;
   } wr_ack_err_t;

   // Full per-channel status view (counter plus error flags).
   typedef struct packed {
      wr_ack_cnt_t cnt;
      wr_ack_err_t err;
   } wr_ack_ch_status_t;

endpackage : ofs_asp_pkg

// File: rtl/wr_ack_word_cnt_ch.sv
// Single write-ack channel: turns one burst write-ack into burstcnt word acks,
// paced by the consumer's ready. Optional input register and pass-through mode.
module wr_ack_word_cnt_ch
   import ofs_asp_pkg::*;
#(
   parameter int BURSTCNT_WIDTH = 7,
   parameter int CNT_WIDTH      = 10,
   parameter int REG_INPUT      = 1,
   parameter int PASS_THRU      = 0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [BURSTCNT_WIDTH-1:0] i_burstcnt,
   input  logic                      i_ack_in,
   input  logic                      i_ack_ready,
   input  logic                      i_err_clr,
   output logic                      o_ack_out,
   output logic [CNT_WIDTH-1:0]      o_cnt,
   output logic                      o_ack_q,
   output logic                      o_ovf_err,
   output logic                      o_zb_err
);

   // Saturation ceiling expressed at the widened (CNT_WIDTH+1) arithmetic width.
   localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

   logic                      w_ack_q;
   logic [BURSTCNT_WIDTH-1:0] w_bc_q;

   // ---- input stage (p0) ----
   generate
      if (REG_INPUT != 0) begin : g_reg_in
         logic                      r_ack_q_p0;
         logic [BURSTCNT_WIDTH-1:0] r_bc_q_p0;

         // Capture the burst ack and its burst count one cycle ahead of the counter.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_ack_q_p0 <= 1'b0;
               r_bc_q_p0  <= '0;
            end else begin
               r_ack_q_p0 <= i_ack_in;
               r_bc_q_p0  <= i_burstcnt;
            end
         end

         assign w_ack_q = r_ack_q_p0;
         assign w_bc_q  = r_bc_q_p0;
      end else begin : g_comb_in
         assign w_ack_q = i_ack_in;
         assign w_bc_q  = i_burstcnt;
      end
   endgenerate

   // ---- counter stage (p1) ----
   logic [CNT_WIDTH-1:0] r_cnt;
   wr_ack_err_t          r_err;

   logic                 w_fire;
   logic                 w_zero_bc;
   logic                 w_zb_evt;
   logic                 w_ovf_evt;
   logic [CNT_WIDTH:0]   w_add;
   logic [CNT_WIDTH:0]   w_sum;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;

   // Word-ack issue, add/subtract at one extra bit, then saturate the result.
   always_comb begin
      w_zero_bc = (w_bc_q == '0);
      w_zb_evt  = w_ack_q & w_zero_bc;
      w_add     = '0;
      if (w_ack_q && !w_zero_bc) begin
         w_add = {{(CNT_WIDTH+1-BURSTCNT_WIDTH){1'b0}}, w_bc_q};
      end

      // Pass-through mirrors the input stage and never touches the counter.
      if (PASS_THRU != 0) begin
         w_fire = w_ack_q;
      end else begin
         w_fire = (r_cnt != '0) & i_ack_ready;
      end

      // Adding the new burst and retiring a word in the same cycle both count.
      w_sum     = {1'b0, r_cnt} + w_add - {{CNT_WIDTH{1'b0}}, w_fire};
      w_ovf_evt = 1'b0;
      w_cnt_nxt = w_sum[CNT_WIDTH-1:0];
      if (PASS_THRU != 0) begin
         w_cnt_nxt = '0;
      end else if (w_sum > CNT_MAX) begin
         w_ovf_evt = 1'b1;
         w_cnt_nxt = CNT_MAX[CNT_WIDTH-1:0];
      end
   end

   // Pending word counter; reset discards any outstanding word acks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   // Sticky error flags; a fresh event in the clear cycle keeps the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= '0;
      end else begin
         r_err.overflow   <= (r_err.overflow   & ~i_err_clr) | w_ovf_evt;
         r_err.zero_burst <= (r_err.zero_burst & ~i_err_clr) | w_zb_evt;
      end
   end

   assign o_ack_out = w_fire;
   assign o_cnt     = r_cnt;
   assign o_ack_q   = w_ack_q;
   assign o_ovf_err = r_err.overflow;
   assign o_zb_err  = r_err.zero_burst;

endmodule : wr_ack_word_cnt_ch

// File: rtl/avmm_wr_ack_burst_to_word_mc.sv
// Multi-channel burst-to-word write-ack converter: one independent
// wr_ack_word_cnt_ch per channel plus a shared idle indication.
module avmm_wr_ack_burst_to_word_mc
   import local_mem_cfg_pkg::*;
   import ofs_asp_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int BURSTCNT_WIDTH = LOCAL_MEM_BURST_CNT_WIDTH,
   parameter int CNT_WIDTH      = WR_ACK_CNT_WIDTH,
   parameter int REG_INPUT      = 1,
   parameter int PASS_THRU      = 0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_CH*BURSTCNT_WIDTH-1:0] burstcnt,
   input  logic [NUM_CH-1:0]            per_burst_write_ack_in,
   input  logic [NUM_CH-1:0]            ack_ready,
   output logic [NUM_CH-1:0]            per_word_write_ack_out,
   output logic [NUM_CH*CNT_WIDTH-1:0]  pending_cnt,
   input  logic                         err_clr,
   output logic [NUM_CH-1:0]            overflow_err,
   output logic [NUM_CH-1:0]            zero_burst_err,
   output logic                         idle
);

   logic [NUM_CH-1:0] w_ack_q;

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         wr_ack_word_cnt_ch #(
            .BURSTCNT_WIDTH (BURSTCNT_WIDTH),
            .CNT_WIDTH      (CNT_WIDTH),
            .REG_INPUT      (REG_INPUT),
            .PASS_THRU      (PASS_THRU)
         ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_burstcnt  (burstcnt[c*BURSTCNT_WIDTH +: BURSTCNT_WIDTH]),
            .i_ack_in    (per_burst_write_ack_in[c]),
            .i_ack_ready (ack_ready[c]),
            .i_err_clr   (err_clr),
            .o_ack_out   (per_word_write_ack_out[c]),
            .o_cnt       (pending_cnt[c*CNT_WIDTH +: CNT_WIDTH]),
            .o_ack_q     (w_ack_q[c]),
            .o_ovf_err   (overflow_err[c]),
            .o_zb_err    (zero_burst_err[c])
         );
      end
   endgenerate

   // Idle once every counter is empty and no burst ack sits in an input stage.
   assign idle = ~(|pending_cnt) & ~(|w_ack_q);

endmodule : avmm_wr_ack_burst_to_word_mc

// File: tb/tb_avmm_wr_ack_burst_to_word_mc.sv
// Bench for avmm_wr_ack_burst_to_word_mc: four configurations driven by one
// shared stimulus and checked every cycle against a counting model.
module tb_avmm_wr_ack_burst_to_word_mc;
   import local_mem_cfg_pkg::*;

   localparam int BWA = LOCAL_MEM_BURST_CNT_WIDTH;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] ack_in;
   logic [1:0] ack_ready;
   logic       err_clr;
   logic [3:0] bc0, bc1;

   logic [2*BWA-1:0] w_bc_a;
   logic [7:0]       w_bc_b;
   assign w_bc_a = {{(BWA-4){1'b0}}, bc1, {(BWA-4){1'b0}}, bc0};
   assign w_bc_b = {bc1, bc0};

   logic [1:0]  ao0, ao1, ao2, ao3;
   logic [1:0]  ov0, ov1, ov2, ov3;
   logic [1:0]  zb0, zb1, zb2, zb3;
   logic [19:0] pc0, pc2, pc3;
   logic [7:0]  pc1;
   logic        id0, id1, id2, id3;

   int checks   = 0;
   int failures = 0;
   int fc0      = 0;
   int fc1      = 0;

   always #5 clk = ~clk;

   // d0: defaults; d1: narrow counter; d2: unregistered input; d3: pass-through
   avmm_wr_ack_burst_to_word_mc #(.NUM_CH(2), .CNT_WIDTH(10), .REG_INPUT(1), .PASS_THRU(0)) u_d0 (
      .clk(clk), .reset_n(reset_n), .burstcnt(w_bc_a), .per_burst_write_ack_in(ack_in),
      .ack_ready(ack_ready), .per_word_write_ack_out(ao0), .pending_cnt(pc0), .err_clr(err_clr),
      .overflow_err(ov0), .zero_burst_err(zb0), .idle(id0));
   avmm_wr_ack_burst_to_word_mc #(.NUM_CH(2), .BURSTCNT_WIDTH(4), .CNT_WIDTH(4), .REG_INPUT(1), .PASS_THRU(0)) u_d1 (
      .clk(clk), .reset_n(reset_n), .burstcnt(w_bc_b), .per_burst_write_ack_in(ack_in),
      .ack_ready(ack_ready), .per_word_write_ack_out(ao1), .pending_cnt(pc1), .err_clr(err_clr),
      .overflow_err(ov1), .zero_burst_err(zb1), .idle(id1));
   avmm_wr_ack_burst_to_word_mc #(.NUM_CH(2), .CNT_WIDTH(10), .REG_INPUT(0), .PASS_THRU(0)) u_d2 (
      .clk(clk), .reset_n(reset_n), .burstcnt(w_bc_a), .per_burst_write_ack_in(ack_in),
      .ack_ready(ack_ready), .per_word_write_ack_out(ao2), .pending_cnt(pc2), .err_clr(err_clr),
      .overflow_err(ov2), .zero_burst_err(zb2), .idle(id2));
   avmm_wr_ack_burst_to_word_mc #(.NUM_CH(2), .CNT_WIDTH(10), .REG_INPUT(1), .PASS_THRU(1)) u_d3 (
      .clk(clk), .reset_n(reset_n), .burstcnt(w_bc_a), .per_burst_write_ack_in(ack_in),
      .ack_ready(ack_ready), .per_word_write_ack_out(ao3), .pending_cnt(pc3), .err_clr(err_clr),
      .overflow_err(ov3), .zero_burst_err(zb3), .idle(id3));

   task automatic chk(input string nm, input int d, input int c, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d ch%0d: got %0d expected %0d (t=%0t)", nm, d, c, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: per configuration, per channel, a pending word count and the
   // previous cycle's inputs; outputs follow directly from those.
   int  cfg_w   [4] = '{10, 4, 10, 10};
   bit  cfg_reg [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   bit  cfg_pt  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   int  m_cnt [4][2];
   bit  m_pa  [4][2];
   int  m_pb  [4][2];
   bit  m_ov  [4][2];
   bit  m_zb  [4][2];

   initial begin : cmp
      logic [1:0] a_ao [4];
      logic [1:0] a_ov [4];
      logic [1:0] a_zb [4];
      int         a_pc [4][2];
      logic       a_id [4];
      bit aq, fire, e_idle, eo, ez;
      int bq, nx, mx, bin;
      for (int d = 0; d < 4; d++)
         for (int c = 0; c < 2; c++) begin
            m_cnt[d][c] = 0; m_pa[d][c] = 0; m_pb[d][c] = 0; m_ov[d][c] = 0; m_zb[d][c] = 0;
         end
      forever begin
         @(negedge clk);
         a_ao = '{ao0, ao1, ao2, ao3};
         a_ov = '{ov0, ov1, ov2, ov3};
         a_zb = '{zb0, zb1, zb2, zb3};
         a_id = '{id0, id1, id2, id3};
         a_pc[0][0] = int'(pc0[9:0]);  a_pc[0][1] = int'(pc0[19:10]);
         a_pc[1][0] = int'(pc1[3:0]);  a_pc[1][1] = int'(pc1[7:4]);
         a_pc[2][0] = int'(pc2[9:0]);  a_pc[2][1] = int'(pc2[19:10]);
         a_pc[3][0] = int'(pc3[9:0]);  a_pc[3][1] = int'(pc3[19:10]);
         for (int d = 0; d < 4; d++) begin
            e_idle = 1'b1;
            mx = (1 << cfg_w[d]) - 1;
            for (int c = 0; c < 2; c++) begin
               if (!reset_n) begin
                  m_cnt[d][c] = 0; m_pa[d][c] = 0; m_pb[d][c] = 0; m_ov[d][c] = 0; m_zb[d][c] = 0;
               end
               bin  = (c == 0) ? int'(bc0) : int'(bc1);
               aq   = cfg_reg[d] ? m_pa[d][c] : ack_in[c];
               bq   = cfg_reg[d] ? m_pb[d][c] : bin;
               fire = cfg_pt[d] ? aq : ((m_cnt[d][c] != 0) && ack_ready[c]);
               chk("ack_out",   d, c, int'(a_ao[d][c]), int'(fire));
               chk("pending",   d, c, a_pc[d][c],       m_cnt[d][c]);
               chk("overflow",  d, c, int'(a_ov[d][c]), int'(m_ov[d][c]));
               chk("zero_burst",d, c, int'(a_zb[d][c]), int'(m_zb[d][c]));
               if (m_cnt[d][c] != 0 || aq) e_idle = 1'b0;
               if (reset_n) begin
                  eo = 1'b0;
                  ez = aq && (bq == 0);
                  if (cfg_pt[d]) nx = 0;
                  else begin
                     nx = m_cnt[d][c] + ((aq && bq != 0) ? bq : 0) - (fire ? 1 : 0);
                     if (nx > mx) begin nx = mx; eo = 1'b1; end
                  end
                  m_cnt[d][c] = nx;
                  if (err_clr) begin m_ov[d][c] = eo; m_zb[d][c] = ez; end
                  else begin m_ov[d][c] = m_ov[d][c] | eo; m_zb[d][c] = m_zb[d][c] | ez; end
                  m_pa[d][c] = ack_in[c];
                  m_pb[d][c] = bin;
               end
            end
            chk("idle", d, 0, int'(a_id[d]), int'(e_idle));
         end
         fc0 += int'(a_ao[0][0]);
         fc1 += int'(a_ao[0][1]);
      end
   end

   initial begin : stim
      int base, p, f;
      reset_n = 1'b1; ack_in = 2'b00; ack_ready = 2'b00; err_clr = 1'b0; bc0 = 4'd0; bc1 = 4'd0;
      #2 reset_n = 1'b0;
      step(2);
      chk("rst_ack_out", 0, 0, int'(ao0), 0);
      chk("rst_pending", 0, 0, int'(pc0), 0);
      chk("rst_errors",  0, 0, int'({ov0, zb0}), 0);
      chk("rst_idle",    0, 0, int'(id0), 1);
      reset_n = 1'b1; ack_ready = 2'b11;
      step(2);

      // burst of 4 on ch0: fires in cycles 2..5 after the ack_in cycle
      base = fc0;
      ack_in = 2'b01; bc0 = 4'd4;
      step(1); ack_in = 2'b00;
      chk("b4_not_yet",    0, 0, int'(ao0[0]), 0);
      chk("b4_noreg_lat1", 2, 0, int'(ao2[0]), 1);
      step(1);
      chk("b4_first",      0, 0, int'(ao0[0]), 1);
      chk("b4_cnt_first",  0, 0, int'(pc0[9:0]), 4);
      step(3);
      chk("b4_last",       0, 0, int'(ao0[0]), 1);
      chk("b4_cnt_last",   0, 0, int'(pc0[9:0]), 1);
      step(1);
      chk("b4_done",       0, 0, int'(ao0[0]), 0);
      chk("b4_cnt_done",   0, 0, int'(pc0[9:0]), 0);
      chk("b4_idle",       0, 0, int'(id0), 1);
      chk("b4_fires",      0, 0, fc0 - base, 4);

      // ch1: burst 3, second burst 2 arrives during the first fire
      base = fc1;
      ack_in = 2'b10; bc1 = 4'd3;
      step(1); ack_in = 2'b00;
      chk("b3b2_idx1", 0, 1, int'(ao0[1]), 0);
      step(1); ack_in = 2'b10; bc1 = 4'd2;
      chk("b3b2_idx2", 0, 1, int'(ao0[1]), 1);
      step(1); ack_in = 2'b00;
      chk("b3b2_idx3", 0, 1, int'(ao0[1]), 1);
      for (int i = 4; i <= 7; i++) begin
         step(1);
         chk("b3b2_run", 0, 1, int'(ao0[1]), (i < 7) ? 1 : 0);
      end
      chk("b3b2_fires", 0, 1, fc1 - base, 5);
      chk("b3b2_cnt",   0, 1, int'(pc0[19:10]), 0);

      // burst 8 with ack_ready toggling on ch0
      base = fc0;
      ack_in = 2'b01; bc0 = 4'd8;
      step(1); ack_in = 2'b00;
      step(1);
      for (int i = 0; i < 20; i++) begin
         ack_ready[0] = (i % 2 == 0);
         #1;
         chk("b8_gate", 0, 0, int'(ao0[0] & ~ack_ready[0]), 0);
         p = int'(pc0[9:0]); f = int'(ao0[0]);
         step(1);
         chk("b8_dec", 0, 0, int'(pc0[9:0]), p - f);
      end
      chk("b8_fires", 0, 0, fc0 - base, 8);
      chk("b8_cnt",   0, 0, int'(pc0[9:0]), 0);
      ack_ready = 2'b11;
      step(2);

      // two bursts of 10 with ready held low: narrow counter saturates
      ack_ready = 2'b00; ack_in = 2'b01; bc0 = 4'd10;
      step(1);
      step(1); ack_in = 2'b00;
      step(2);
      chk("ovf_sat",     1, 0, int'(pc1[3:0]), 15);
      chk("ovf_flag",    1, 0, int'(ov1[0]), 1);
      chk("ovf_wide",    0, 0, int'(pc0[9:0]), 20);
      chk("ovf_wide_ok", 0, 0, int'(ov0[0]), 0);
      err_clr = 1'b1;
      step(1); err_clr = 1'b0;
      chk("ovf_clr",     1, 0, int'(ov1[0]), 0);
      ack_ready = 2'b11;
      step(25);

      // zero-length burst; clear coinciding with the registered event
      ack_in = 2'b01; bc0 = 4'd0;
      step(1); ack_in = 2'b00; err_clr = 1'b1;
      step(1); err_clr = 1'b0;
      chk("zb_event_wins", 0, 0, int'(zb0[0]), 1);
      chk("zb_clear_wins", 2, 0, int'(zb2[0]), 0);
      chk("zb_no_add",     0, 0, int'(pc0[9:0]), 0);
      err_clr = 1'b1;
      step(1); err_clr = 1'b0;
      step(1);
      chk("zb_cleared",    0, 0, int'(zb0[0]), 0);

      // burst of 6, reset after two fires
      ack_in = 2'b01; bc0 = 4'd6;
      step(1); ack_in = 2'b00;
      step(1);
      chk("rst6_fire1", 0, 0, int'(ao0[0]), 1);
      step(1);
      chk("rst6_fire2", 0, 0, int'(ao0[0]), 1);
      chk("rst6_cnt",   0, 0, int'(pc0[9:0]), 5);
      step(1);
      reset_n = 1'b0;
      #1;
      chk("rst6_ack_out", 0, 0, int'(ao0), 0);
      chk("rst6_pending", 0, 0, int'(pc0), 0);
      chk("rst6_idle",    0, 0, int'(id0), 1);
      chk("rst6_noreg",   2, 0, int'(pc2), 0);
      step(1); reset_n = 1'b1;
      base = fc0;
      step(10);
      chk("rst6_no_fires", 0, 0, fc0 - base, 0);
      chk("rst6_cnt_end",  0, 0, int'(pc0[9:0]), 0);

      // pass-through: 1,0,1 pattern delayed one cycle, counters stay 0
      ack_in = 2'b01; bc0 = 4'd5;
      step(1); ack_in = 2'b00;
      chk("pt_1", 3, 0, int'(ao3[0]), 1);
      chk("pt_cnt", 3, 0, int'(pc3), 0);
      step(1); ack_in = 2'b01;
      chk("pt_0", 3, 0, int'(ao3[0]), 0);
      step(1); ack_in = 2'b00;
      chk("pt_1b", 3, 0, int'(ao3[0]), 1);
      step(1);
      chk("pt_end", 3, 0, int'(ao3[0]), 0);
      chk("pt_cnt_end", 3, 0, int'(pc3), 0);
      step(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_avmm_wr_ack_burst_to_word_mc
